// File: rtl/btn_sw_input_ctrl_if.sv
// CPU-side register port of btn_sw_input_ctrl.
//   rd_en   : register read strobe (CPU -> peripheral)
//   wr_en   : register write strobe (CPU -> peripheral)
//   addr    : 2-bit register address (CPU -> peripheral)
//   wdata   : 16-bit write data (CPU -> peripheral)
//   rd_data : 16-bit registered read data (peripheral -> CPU)
//   irq     : level interrupt request (peripheral -> CPU)
interface btn_sw_input_ctrl_if;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rd_data;
    logic        irq;

    modport master (
        output rd_en,
        output wr_en,
        output addr,
        output wdata,
        input  rd_data,
        input  irq
    );

    modport slave (
        input  rd_en,
        input  wr_en,
        input  addr,
        input  wdata,
        output rd_data,
        output irq
    );
endinterface

// File: rtl/btn_sw_input_ctrl.sv
// Button/switch input peripheral: synchronises and debounces active-low
// push-buttons, synchronises slide switches, latches press events as pending
// interrupt flags and exposes everything through a small register port.
//   clk         : system clock, rising edge
//   reset       : synchronous, active-high
//   buttons     : raw active-low buttons (asynchronous)
//   switches    : raw switches (asynchronous)
//   bus         : register port (rd_en/wr_en/addr/wdata in, rd_data/irq out)
//   btn_pressed : debounced button state, 1 = pressed
// Register map: 0 btn_pressed (R), 1 switches (R), 2 pend (R, clear-on-read),
// 3 mask (R/W, resets to all ones).
module btn_sw_input_ctrl #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned N_SW            = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BTN-1:0]     buttons,
    input  logic [N_SW-1:0]      switches,
    btn_sw_input_ctrl_if.slave   bus,
    output logic [N_BTN-1:0]     btn_pressed
);

    localparam int unsigned DATA_W = 16;
    localparam logic [1:0] ADDR_BTN  = 2'd0;
    localparam logic [1:0] ADDR_SW   = 2'd1;
    localparam logic [1:0] ADDR_PEND = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Synchroniser chains; button flops hold raw (active-low) levels.
    logic [N_BTN-1:0]  btn_meta;
    logic [N_BTN-1:0]  btn_sync_n;
    logic [N_BTN-1:0]  btn_sync;
    logic [N_SW-1:0]   sw_meta;
    logic [N_SW-1:0]   sw_sync;

    logic [CNT_W-1:0]  cnt      [N_BTN];
    logic [CNT_W-1:0]  cnt_next [N_BTN];
    logic [N_BTN-1:0]  btn_next;
    logic [N_BTN-1:0]  press_c;
    logic [N_BTN-1:0]  pend;
    logic [N_BTN-1:0]  pend_next;
    logic [N_BTN-1:0]  pend_clr;
    logic [N_BTN-1:0]  mask;
    logic [DATA_W-1:0] rd_next;
    logic              rd_pend;
    logic              wr_mask;

    // Only wdata[N_BTN-1:0] is meaningful; fold the rest away explicitly.
    logic unused_wdata;
    assign unused_wdata = &{1'b0, bus.wdata};

    assign btn_sync = ~btn_sync_n;

    // Debounce: count consecutive disagreeing samples, accept on the last one.
    always_comb begin
        btn_next = btn_pressed;
        press_c  = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            cnt_next[i] = '0;
            if (btn_sync[i] != btn_pressed[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    btn_next[i] = btn_sync[i];
                    press_c[i]  = btn_sync[i];
                end else begin
                    cnt_next[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Register decode; a new press edge wins over a clear-on-read of the same bit.
    always_comb begin
        rd_pend   = bus.rd_en && (bus.addr == ADDR_PEND);
        wr_mask   = bus.wr_en && (bus.addr == 2'd3);
        pend_clr  = rd_pend ? pend : '0;
        pend_next = (pend & ~pend_clr) | press_c;
        case (bus.addr)
            ADDR_BTN:  rd_next = DATA_W'(btn_pressed);
            ADDR_SW:   rd_next = DATA_W'(sw_sync);
            ADDR_PEND: rd_next = DATA_W'(pend);
            default:   rd_next = DATA_W'(mask);
        endcase
    end

    // State registers; rd_data samples pre-write mask on a combined read/write.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_meta    <= '1;
            btn_sync_n  <= '1;
            sw_meta     <= '0;
            sw_sync     <= '0;
            btn_pressed <= '0;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt[i] <= '0;
            end
            pend        <= '0;
            mask        <= '1;
            bus.irq     <= 1'b0;
            bus.rd_data <= '0;
        end else begin
            btn_meta    <= buttons;
            btn_sync_n  <= btn_meta;
            sw_meta     <= switches;
            sw_sync     <= sw_meta;
            btn_pressed <= btn_next;
            for (int i = 0; i < int'(N_BTN); i++) begin
                cnt[i] <= cnt_next[i];
            end
            pend        <= pend_next;
            if (wr_mask) begin
                mask <= bus.wdata[N_BTN-1:0];
            end
            bus.irq     <= |(pend & mask);
            if (bus.rd_en) begin
                bus.rd_data <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_btn_sw_input_ctrl.sv
// Directed bench for btn_sw_input_ctrl with default parameters
// (4 buttons, 10 switches, 4-sample debounce).
module tb_btn_sw_input_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] buttons;
    logic [9:0] switches;
    logic [3:0] btn_pressed;

    int n_cmp;
    int n_err;

    btn_sw_input_ctrl_if bus ();

    btn_sw_input_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .buttons     (buttons),
        .switches    (switches),
        .bus         (bus),
        .btn_pressed (btn_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a);
        bus.rd_en = 1'b1;
        bus.addr  = a;
        tick(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus.wr_en = 1'b1;
        bus.addr  = a;
        bus.wdata = d;
        tick(1);
        bus.wr_en = 1'b0;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        buttons   = 4'b1111;
        switches  = 10'h155;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.addr  = 2'd0;
        bus.wdata = 16'h0000;

        // Reset state
        tick(2);
        reset = 1'b0;
        check("rst_rd_data", bus.rd_data, 16'h0000);
        check("rst_irq", 16'(bus.irq), 16'h0000);
        check("rst_btn", 16'(btn_pressed), 16'h0000);
        rd(2'd3);
        check("rst_mask", bus.rd_data, 16'h000F);
        tick(2);
        rd(2'd1);
        check("sw_155", bus.rd_data, 16'h0155);

        // Debounced press of button 0: accepted on the 6th edge
        buttons = 4'b1110;
        tick(5);
        check("press0_early", 16'(btn_pressed), 16'h0000);
        tick(1);
        check("press0_edge6", 16'(btn_pressed), 16'h0001);
        check("press0_irq_lat", 16'(bus.irq), 16'h0000);
        tick(1);
        check("press0_irq", 16'(bus.irq), 16'h0001);
        rd(2'd2);
        check("pend_rd1", bus.rd_data, 16'h0001);
        check("irq_at_clear", 16'(bus.irq), 16'h0001);
        tick(1);
        check("irq_after_clear", 16'(bus.irq), 16'h0000);
        rd(2'd2);
        check("pend_rd2", bus.rd_data, 16'h0000);
        buttons = 4'b1111;
        tick(8);
        check("release0_btn", 16'(btn_pressed), 16'h0000);
        rd(2'd2);
        check("release0_pend", bus.rd_data, 16'h0000);
        check("release0_irq", 16'(bus.irq), 16'h0000);

        // Glitch of 3 samples rejected, 4 samples accepted
        buttons = 4'b1101;
        tick(3);
        buttons = 4'b1111;
        tick(8);
        check("glitch3_btn", 16'(btn_pressed), 16'h0000);
        check("glitch3_irq", 16'(bus.irq), 16'h0000);
        rd(2'd2);
        check("glitch3_pend", bus.rd_data, 16'h0000);
        buttons = 4'b1101;
        tick(4);
        buttons = 4'b1111;
        tick(10);
        check("glitch4_btn", 16'(btn_pressed), 16'h0000);
        rd(2'd2);
        check("glitch4_pend", bus.rd_data, 16'h0002);
        tick(1);
        check("glitch4_irq_clr", 16'(bus.irq), 16'h0000);

        // Mask out button 0, press it, then unmask
        wr(2'd3, 16'h000E);
        rd(2'd3);
        check("mask_e", bus.rd_data, 16'h000E);
        buttons = 4'b1110;
        tick(9);
        check("mask_btn", 16'(btn_pressed), 16'h0001);
        check("mask_irq_off", 16'(bus.irq), 16'h0000);
        wr(2'd3, 16'h000F);
        check("unmask_irq_k", 16'(bus.irq), 16'h0000);
        tick(1);
        check("unmask_irq_k1", 16'(bus.irq), 16'h0001);

        // Clear-read of pend on the same edge as button 2's press edge
        buttons = 4'b1010;
        tick(5);
        check("sc_pre_btn", 16'(btn_pressed), 16'h0001);
        rd(2'd2);
        check("sc_rd", bus.rd_data, 16'h0001);
        check("sc_btn", 16'(btn_pressed), 16'h0005);
        check("sc_irq0", 16'(bus.irq), 16'h0001);
        tick(1);
        check("sc_irq1", 16'(bus.irq), 16'h0001);
        rd(2'd2);
        check("sc_pend", bus.rd_data, 16'h0004);
        buttons = 4'b1111;
        tick(8);
        check("sc_release", 16'(btn_pressed), 16'h0000);
        check("sc_irq_end", 16'(bus.irq), 16'h0000);

        // Combined read/write of mask returns the pre-write value
        bus.rd_en = 1'b1;
        wr(2'd3, 16'h0003);
        bus.rd_en = 1'b0;
        check("rw_old", bus.rd_data, 16'h000F);
        rd(2'd3);
        check("rw_new", bus.rd_data, 16'h0003);
        wr(2'd3, 16'h000F);

        // Writes to read-only addresses are ignored
        wr(2'd0, 16'hFFFF);
        rd(2'd0);
        check("ro_btn", bus.rd_data, 16'h0000);

        // Switch synchronisation
        switches = 10'h2AA;
        tick(2);
        rd(2'd1);
        check("sw_2aa", bus.rd_data, 16'h02AA);
        check("rd_hold", bus.rd_data, 16'h02AA);
        tick(3);
        check("rd_hold2", bus.rd_data, 16'h02AA);

        // Reset mid-debounce discards the partial count
        buttons = 4'b0111;
        tick(4);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check("mid_rst_btn", 16'(btn_pressed), 16'h0000);
        check("mid_rst_rd", bus.rd_data, 16'h0000);
        check("mid_rst_irq", 16'(bus.irq), 16'h0000);
        tick(5);
        check("reaccept_early", 16'(btn_pressed), 16'h0000);
        tick(1);
        check("reaccept", 16'(btn_pressed), 16'h0008);
        tick(1);
        check("reaccept_irq", 16'(bus.irq), 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
